// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_drive-side byte channels of uart_tx_arbiter.
// slave = arbiter view, master = user/testbench view.
interface uart_tx_arbiter_if #(
  parameter int P_REQ_NUM    = 4,
  parameter int P_DATA_WIDTH = 8
);
  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data;
  logic [P_REQ_NUM-1:0]              i_req_valid;
  logic [P_REQ_NUM-1:0]              i_req_last;
  logic [P_REQ_NUM-1:0]              o_req_ready;
  logic [P_DATA_WIDTH-1:0]           o_user_tx_data;
  logic                              o_user_tx_valid;
  logic                              i_user_tx_ready;

  modport slave (
    input  i_req_data, i_req_valid, i_req_last, i_user_tx_ready,
    output o_req_ready, o_user_tx_data, o_user_tx_valid
  );

  modport master (
    output i_req_data, i_req_valid, i_req_last, i_user_tx_ready,
    input  o_req_ready, o_user_tx_data, o_user_tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter onto the uart_drive TX channel; idle watchdog under `UART_ARB_TIMEOUT_EN.
// Grant 1 cycle after request, then zero-bubble passthrough; owner sees i_user_tx_ready as its ready.
module uart_tx_arbiter #(
  parameter  int P_REQ_NUM    = 4,
  parameter  int P_DATA_WIDTH = 8,
  parameter  int P_TIMEOUT    = 1024,
  localparam int LP_IDW       = $clog2(P_REQ_NUM)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic [LP_IDW-1:0] o_grant_id,
  output logic              o_busy,
  output logic              o_timeout
);

  if (P_REQ_NUM < 2 || P_REQ_NUM > 8 || P_TIMEOUT < 2) begin : g_param_err
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t              r_state, w_state_nxt;
  logic [LP_IDW-1:0]   r_grant, w_grant_nxt;
  logic [LP_IDW-1:0]   r_rr_last, w_rr_last_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [LP_IDW-1:0]   w_pick, w_cand;
  logic                w_any;
  logic                w_g_valid;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_expire;
  logic [P_DATA_WIDTH-1:0] w_req_bytes [P_REQ_NUM];

  for (genvar gi = 0; gi < P_REQ_NUM; gi++) begin : g_bytes
    assign w_req_bytes[gi] = bus.i_req_data[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  // First valid requester after the previous winner, wrapping around.
  always_comb begin : p_pick
    int w_idx;
    w_pick = '0;
    w_cand = '0;
    w_any  = 1'b0;
    w_idx  = 0;
    for (int i = 1; i <= P_REQ_NUM; i++) begin
      w_idx = int'(r_rr_last) + i;
      if (w_idx >= P_REQ_NUM) w_idx = w_idx - P_REQ_NUM;
      w_cand = LP_IDW'(w_idx);
      if (!w_any && bus.i_req_valid[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  assign w_g_valid   = bus.i_req_valid[r_grant];
  assign w_beat      = (r_state == S_XFER) && w_g_valid && bus.i_user_tx_ready;
  assign w_last_beat = w_beat && bus.i_req_last[r_grant];

  always_comb begin : p_passthru
    bus.o_req_ready     = '0;
    bus.o_user_tx_valid = 1'b0;
    bus.o_user_tx_data  = '0;
    if (r_state == S_XFER) begin
      bus.o_user_tx_data       = w_req_bytes[r_grant];
      bus.o_user_tx_valid      = w_g_valid;
      bus.o_req_ready[r_grant] = bus.i_user_tx_ready;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int LP_CW = $clog2(P_TIMEOUT + 1);

  logic [LP_CW-1:0] r_cnt, w_cnt_nxt;

  // Only starved cycles count; a stalled-but-valid owner is not idle.
  assign w_expire = (r_state == S_XFER) && !w_g_valid &&
                    (r_cnt == LP_CW'(P_TIMEOUT - 1));

  always_comb begin : p_cnt_nxt
    w_cnt_nxt = r_cnt;
    if (r_state != S_XFER || w_beat || w_expire) begin
      w_cnt_nxt = '0;
    end else if (!w_g_valid) begin
      w_cnt_nxt = r_cnt + LP_CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin : p_fsm_nxt
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_last_nxt = r_rr_last;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt   = S_XFER;
          w_grant_nxt   = w_pick;
          w_rr_last_nxt = w_pick;
        end
      end
      S_XFER: begin
        if (w_last_beat) begin
          w_state_nxt = S_IDLE;
        end else if (w_expire) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_last <= LP_IDW'(P_REQ_NUM - 1);
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr_last <= w_rr_last_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_grant_id = r_grant;
  assign o_busy     = (r_state == S_XFER);
  assign o_timeout  = r_timeout;

endmodule
